// File: rtl/proc_pkg.sv
// Shared types and field positions for the multicycle processor datapath.
// Instruction layout is the classic 32-bit R/I format.
package proc_pkg;

    localparam int DEF_DW = 32;
    localparam int DEF_AW = 5;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
    localparam int FN_MSB  = 5;
    localparam int FN_LSB  = 0;

    localparam logic [5:0] OPC_RTYPE = 6'h00;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        READ,
        CAPTURE,
        ISSUE
    } state_e;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/instr_fields.sv
// Combinational split of an instruction word into selects, opcode, funct,
// sign-extended immediate and the destination register.
module instr_fields
    import proc_pkg::*;
(
    input  logic [31:0] ir_i,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [5:0]  opcode_o,
    output logic [5:0]  funct_o,
    output logic [31:0] imm_o,
    output logic [4:0]  dest_o
);

    assign rs_o     = ir_i[RS_MSB:RS_LSB];
    assign rt_o     = ir_i[RT_MSB:RT_LSB];
    assign opcode_o = ir_i[OPC_MSB:OPC_LSB];
    assign funct_o  = ir_i[FN_MSB:FN_LSB];
    assign imm_o    = sext16(ir_i[IMM_MSB:IMM_LSB]);

    // R-type writes rd; every other format writes rt.
    assign dest_o = (opcode_o == OPC_RTYPE) ? ir_i[RD_MSB:RD_LSB] : ir_i[RT_MSB:RT_LSB];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch / writeback sequencer: one register transaction in flight,
// instruction to op_valid in 3 cycles, ISSUE holds until op_ready.
module operand_fetch
    import proc_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [DW-1:0] instr,
    input  logic          wb_valid,
    output logic          wb_ready,
    input  logic [AW-1:0] wb_rd,
    input  logic [DW-1:0] wb_data,
    output logic [AW-1:0] rs,
    output logic [AW-1:0] rt,
    output logic [AW-1:0] rd,
    output logic [DW-1:0] i_data,
    input  logic [DW-1:0] rf_data_a,
    input  logic [DW-1:0] rf_data_b,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    output logic [DW-1:0] op_imm,
    output logic [5:0]    op_opcode,
    output logic [5:0]    op_funct,
    output logic [AW-1:0] op_rd
);

    state_e        state_q, state_d;
    logic [DW-1:0] ir_q;
    logic [AW-1:0] wb_rd_q;
    logic [DW-1:0] wb_data_q;
    logic [DW-1:0] op_a_q, op_b_q, op_imm_q;
    logic [5:0]    op_opcode_q, op_funct_q;
    logic [AW-1:0] op_rd_q;

    logic [4:0]  f_rs, f_rt, f_dest;
    logic [5:0]  f_opcode, f_funct;
    logic [31:0] f_imm;

    logic instr_fire, wb_fire, reading;

    instr_fields u_fields (
        .ir_i     (ir_q[31:0]),
        .rs_o     (f_rs),
        .rt_o     (f_rt),
        .opcode_o (f_opcode),
        .funct_o  (f_funct),
        .imm_o    (f_imm),
        .dest_o   (f_dest)
    );

    // A pending writeback blocks instruction acceptance so it lands first.
    assign wb_ready    = (state_q == IDLE);
    assign instr_ready = (state_q == IDLE) && !wb_valid;
    assign wb_fire     = wb_valid && wb_ready;
    assign instr_fire  = instr_valid && instr_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wb_fire)         state_d = WB;
                else if (instr_fire) state_d = READ;
            end
            WB:      state_d = IDLE;
            READ:    state_d = CAPTURE;
            CAPTURE: state_d = ISSUE;
            ISSUE:   if (op_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ir_q        <= '0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_imm_q    <= '0;
            op_opcode_q <= '0;
            op_funct_q  <= '0;
            op_rd_q     <= '0;
        end else begin
            state_q <= state_d;
            if (instr_fire) ir_q <= instr;
            if (wb_fire) begin
                wb_rd_q   <= wb_rd;
                wb_data_q <= wb_data;
            end
            if (state_q == CAPTURE) begin
                op_a_q      <= rf_data_a;
                op_b_q      <= rf_data_b;
                op_imm_q    <= DW'(f_imm);
                op_opcode_q <= f_opcode;
                op_funct_q  <= f_funct;
                op_rd_q     <= AW'(f_dest);
            end
        end
    end

    // Zero selects elsewhere address the hardwired-zero register, i.e. no-op.
    assign reading = (state_q == READ) || (state_q == CAPTURE);
    assign rs      = reading ? AW'(f_rs) : '0;
    assign rt      = reading ? AW'(f_rt) : '0;
    assign rd      = (state_q == WB) ? wb_rd_q : '0;
    assign i_data  = wb_data_q;

    assign op_valid  = (state_q == ISSUE);
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_imm    = op_imm_q;
    assign op_opcode = op_opcode_q;
    assign op_funct  = op_funct_q;
    assign op_rd     = op_rd_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: behavioural register file plus a shadow model of
// register contents; expected bundles are queued at accept and popped at issue.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid, instr_ready;
    logic [31:0] instr;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  rs, rt, rd;
    logic [31:0] i_data, rf_data_a, rf_data_b;
    logic        op_valid, op_ready;
    logic [31:0] op_a, op_b, op_imm;
    logic [5:0]  op_opcode, op_funct;
    logic [4:0]  op_rd;

    int errors = 0;
    int checks = 0;
    int xfers = 0;
    int exp_xfers = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [4:0]  rdst;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] regs[32];
    logic [31:0] mregs[32];

    always #5 clk = ~clk;

    operand_fetch #(.DW(32), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .rs(rs), .rt(rt), .rd(rd), .i_data(i_data),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_imm(op_imm),
        .op_opcode(op_opcode), .op_funct(op_funct), .op_rd(op_rd)
    );

    // Register slots: r0 reads zero and ignores writes.
    always @(posedge clk) if (rd != 5'd0) regs[rd] <= i_data;
    assign rf_data_a = regs[rs];
    assign rf_data_b = regs[rt];

    always @(posedge clk) if (!rst && op_valid && op_ready) xfers++;

    function automatic exp_t model(input logic [31:0] ins);
        exp_t e;
        e.a    = mregs[ins[25:21]];
        e.b    = mregs[ins[20:16]];
        e.imm  = {{16{ins[15]}}, ins[15:0]};
        e.opc  = ins[31:26];
        e.fn   = ins[5:0];
        e.rdst = (ins[31:26] == 6'd0) ? ins[15:11] : ins[20:16];
        return e;
    endfunction

    // Called at a negedge; returns at the negedge two cycles after accept.
    task automatic do_wb(input logic [4:0] r, input logic [31:0] d);
        int n = 0;
        wb_valid = 1'b1; wb_rd = r; wb_data = d;
        while (!wb_ready && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (n >= 20) begin errors++; $display("FAIL wb_accept_timeout: wb_ready=%0b required 1", wb_ready); end
        @(negedge clk);
        wb_valid = 1'b0; wb_rd = $urandom; wb_data = $urandom;
        if (r != 5'd0) mregs[r] = d;
        checks++;
        if ({rd, i_data, rs, rt} !== {r, d, 5'd0, 5'd0}) begin
            errors++;
            $display("FAIL wb_drive: rd=%0d i_data=%h rs=%0d rt=%0d required rd=%0d i_data=%h rs=0 rt=0", rd, i_data, rs, rt, r, d);
        end
        @(negedge clk);
        checks++;
        if ({rd, i_data, wb_ready} !== {5'd0, d, 1'b1}) begin
            errors++;
            $display("FAIL wb_after: rd=%0d i_data=%h wb_ready=%0b required rd=0 i_data=%h wb_ready=1", rd, i_data, wb_ready, d);
        end
    endtask

    // Called at a negedge with the instruction about to be offered.
    task automatic run_instr(input logic [31:0] ins, input int stall, output int waited,
                             output logic [31:0] g_a, output logic [31:0] g_b, output logic [31:0] g_imm,
                             output logic [5:0] g_opc, output logic [5:0] g_fn, output logic [4:0] g_rd);
        exp_t e;
        int   n = 0;
        instr_valid = 1'b1; instr = ins; op_ready = (stall == 0);
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        waited = n;
        checks++;
        if (n >= 20) begin errors++; $display("FAIL instr_accept_timeout: instr_ready=%0b required 1", instr_ready); end
        expq.push_back(model(ins));
        @(negedge clk);
        instr_valid = 1'b0; instr = $urandom;
        checks++;
        if ({rs, rt, rd, instr_ready, op_valid} !== {ins[25:21], ins[20:16], 5'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL read_sel: rs=%0d rt=%0d rd=%0d rdy=%0b vld=%0b required rs=%0d rt=%0d rd=0 rdy=0 vld=0",
                     rs, rt, rd, instr_ready, op_valid, ins[25:21], ins[20:16]);
        end
        @(negedge clk);
        checks++;
        if ({rs, rt, op_valid} !== {ins[25:21], ins[20:16], 1'b0}) begin
            errors++;
            $display("FAIL capture_sel: rs=%0d rt=%0d vld=%0b required rs=%0d rt=%0d vld=0", rs, rt, op_valid, ins[25:21], ins[20:16]);
        end
        @(negedge clk);
        checks++;
        if (op_valid !== 1'b1) begin errors++; $display("FAIL issue_latency: op_valid=%0b required 1", op_valid); end
        e = expq.pop_front();
        g_a = op_a; g_b = op_b; g_imm = op_imm; g_opc = op_opcode; g_fn = op_funct; g_rd = op_rd;
        checks++;
        if ({op_a, op_b, op_imm, op_opcode, op_funct, op_rd, rs, rt} !== {e.a, e.b, e.imm, e.opc, e.fn, e.rdst, 10'd0}) begin
            errors++;
            $display("FAIL bundle: a=%h b=%h imm=%h opc=%h fn=%h rd=%0d rs=%0d rt=%0d required a=%h b=%h imm=%h opc=%h fn=%h rd=%0d rs=0 rt=0",
                     op_a, op_b, op_imm, op_opcode, op_funct, op_rd, rs, rt, e.a, e.b, e.imm, e.opc, e.fn, e.rdst);
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checks++;
            if ({op_valid, instr_ready, wb_ready, op_a, op_b, op_imm, op_opcode, op_funct, op_rd} !==
                {1'b1, 1'b0, 1'b0, e.a, e.b, e.imm, e.opc, e.fn, e.rdst}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: vld=%0b irdy=%0b wrdy=%0b a=%h b=%h rd=%0d required vld=1 irdy=0 wrdy=0 a=%h b=%h rd=%0d",
                         i, op_valid, instr_ready, wb_ready, op_a, op_b, op_rd, e.a, e.b, e.rdst);
            end
        end
        op_ready = 1'b1;
        exp_xfers++;
        @(negedge clk);
        checks++;
        if ({op_valid, instr_ready, wb_ready} !== 3'b011) begin
            errors++;
            $display("FAIL back_to_idle: vld=%0b irdy=%0b wrdy=%0b required vld=0 irdy=1 wrdy=1", op_valid, instr_ready, wb_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_valid = 1'b0; wb_valid = 1'b0; op_ready = 1'b1;
        instr = '0; wb_rd = '0; wb_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({instr_ready, wb_ready, op_valid, rs, rt, rd, i_data, op_a, op_b, op_imm, op_opcode, op_funct, op_rd} !==
                {1'b1, 1'b1, 1'b0, 15'd0, 32'd0, 96'd0, 6'd0, 6'd0, 5'd0}) begin
                errors++;
                $display("FAIL reset_state[%0d]: irdy=%0b wrdy=%0b vld=%0b rs=%0d rt=%0d rd=%0d i_data=%h a=%h b=%h imm=%h required 1 1 0 and all zero",
                         i, instr_ready, wb_ready, op_valid, rs, rt, rd, i_data, op_a, op_b, op_imm);
            end
        end
    endtask

    task automatic test_add();
        int w; logic [31:0] a, b, im; logic [5:0] oc, fn; logic [4:0] d;
        do_wb(5'd1, 32'h0000_000A);
        do_wb(5'd2, 32'h0000_0005);
        run_instr(32'h0022_1820, 0, w, a, b, im, oc, fn, d);
        checks++;
        if ({a, b, d, fn, oc} !== {32'hA, 32'h5, 5'd3, 6'h20, 6'h00}) begin
            errors++;
            $display("FAIL add_result: a=%h b=%h rd=%0d fn=%h opc=%h required a=a b=5 rd=3 fn=20 opc=0", a, b, d, fn, oc);
        end
    endtask

    task automatic test_addi();
        int w; logic [31:0] a, b, im; logic [5:0] oc, fn; logic [4:0] d;
        do_wb(5'd4, 32'h1234_5678);
        run_instr(32'h2085_FFFF, 0, w, a, b, im, oc, fn, d);
        checks++;
        if ({oc, im, d, a} !== {6'h08, 32'hFFFF_FFFF, 5'd5, 32'h1234_5678}) begin
            errors++;
            $display("FAIL addi_result: opc=%h imm=%h rd=%0d a=%h required opc=08 imm=ffffffff rd=5 a=12345678", oc, im, d, a);
        end
    endtask

    task automatic test_priority();
        int w; logic [31:0] a, b, im; logic [5:0] oc, fn; logic [4:0] d;
        instr_valid = 1'b1; instr = 32'h00E0_4020;  // add $8,$7,$0
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hCAFE_0007; op_ready = 1'b1;
        checks++;
        if (wb_ready !== 1'b1) begin errors++; $display("FAIL prio_wb_ready: wb_ready=%0b required 1", wb_ready); end
        @(negedge clk);
        wb_valid = 1'b0;
        mregs[7] = 32'hCAFE_0007;
        checks++;
        if ({rd, rs, instr_ready} !== {5'd7, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL prio_wb_first: rd=%0d rs=%0d irdy=%0b required rd=7 rs=0 irdy=0", rd, rs, instr_ready);
        end
        @(negedge clk);
        checks++;
        if ({rd, instr_ready} !== {5'd0, 1'b1}) begin
            errors++;
            $display("FAIL prio_wb_len: rd=%0d irdy=%0b required rd=0 irdy=1", rd, instr_ready);
        end
        run_instr(32'h00E0_4020, 0, w, a, b, im, oc, fn, d);
        checks++;
        if ({w, a, d} !== {32'd0, 32'hCAFE_0007, 5'd8}) begin
            errors++;
            $display("FAIL prio_instr: waited=%0d a=%h rd=%0d required waited=0 a=cafe0007 rd=8", w, a, d);
        end
    endtask

    task automatic test_stall();
        int w; logic [31:0] a, b, im; logic [5:0] oc, fn; logic [4:0] d;
        run_instr(32'h0041_2822, 5, w, a, b, im, oc, fn, d);  // sub $5,$2,$1
        checks++;
        if (xfers !== exp_xfers) begin
            errors++;
            $display("FAIL stall_xfers: transfers=%0d required %0d", xfers, exp_xfers);
        end
    endtask

    task automatic test_reset_mid();
        int w; logic [31:0] a, b, im; logic [5:0] oc, fn; logic [4:0] d;
        instr_valid = 1'b1; instr = 32'h0022_1820; op_ready = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({instr_ready, op_valid, rs, rt, op_a} !== {1'b1, 1'b0, 10'd0, 32'd0}) begin
            errors++;
            $display("FAIL rst_mid_idle: irdy=%0b vld=%0b rs=%0d rt=%0d a=%h required irdy=1 vld=0 rs=0 rt=0 a=0",
                     instr_ready, op_valid, rs, rt, op_a);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (op_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_dropped[%0d]: op_valid=%0b required 0", i, op_valid); end
        end
        run_instr(32'h0022_1820, 0, w, a, b, im, oc, fn, d);
        checks++;
        if ({a, b, d} !== {32'hA, 32'h5, 5'd3}) begin
            errors++;
            $display("FAIL rst_mid_next: a=%h b=%h rd=%0d required a=a b=5 rd=3", a, b, d);
        end
    endtask

    task automatic test_back_to_back();
        int w; logic [31:0] a, b, im, ins; logic [5:0] oc, fn; logic [4:0] d;
        for (int i = 0; i < 6; i++) begin
            do_wb(5'($urandom_range(1, 31)), $urandom);
        end
        for (int i = 0; i < 8; i++) begin
            ins = $urandom;
            if (i % 2 == 0) ins[31:26] = 6'd0;
            run_instr(ins, 0, w, a, b, im, oc, fn, d);
            checks++;
            if (w != 0) begin errors++; $display("FAIL b2b_spacing[%0d]: waited=%0d required 0", i, w); end
        end
        checks++;
        if (xfers !== exp_xfers || expq.size() != 0) begin
            errors++;
            $display("FAIL b2b_xfers: transfers=%0d pending=%0d required %0d and 0", xfers, expq.size(), exp_xfers);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin regs[i] = '0; mregs[i] = '0; end
        @(negedge clk);
        test_reset();
        test_add();
        test_addi();
        test_priority();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
